// File: rtl/nand_avalon_host_if.sv
// Host command/response handshake and Avalon-style register bus of the NAND controller host.
// The master modport is the host engine's view; slave is the environment's view.
interface nand_avalon_host_if #(
  parameter int unsigned CW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_code;
  logic [7:0]    cmd_wdata;
  logic          cmd_has_wdata;
  logic          cmd_has_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_rdata;
  logic          rsp_timeout;
  logic          init_done;
  logic [1:0]    address;
  logic [31:0]   writedata;
  logic          pwrite;
  logic          pread;
  logic [31:0]   readdata;

  modport master (
    input  cmd_valid, cmd_code, cmd_wdata, cmd_has_wdata, cmd_has_rdata, rsp_ready, readdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, init_done,
    output address, writedata, pwrite, pread
  );

  modport slave (
    output cmd_valid, cmd_code, cmd_wdata, cmd_has_wdata, cmd_has_rdata, rsp_ready, readdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, init_done,
    input  address, writedata, pwrite, pread
  );
endinterface

// File: rtl/nand_avalon_host.sv
// Sequences host commands into DATA/CMD register writes, polls STATUS until the controller
// is ready (bounded by POLL_TIMEOUT) and optionally reads DATA back. All outputs registered.
module nand_avalon_host #(
  parameter logic [15:0] POLL_TIMEOUT = 16'd50000,
  parameter int unsigned CW           = 5
) (
  input logic                clk,
  input logic                resetn,
  nand_avalon_host_if.master bus
);

  typedef enum logic [3:0] {
    StInit, StIdle, StWrData, StWrDataGap, StWrCmd, StWrCmdGap,
    StPoll, StPollGap, StRdData, StRdGap, StResp
  } state_e;

  state_e        state_q;
  logic [CW-1:0] code_q;
  logic [7:0]    wdata_q;
  logic          has_rdata_q;
  logic [1:0]    status_q;
  logic [7:0]    rdata_q;
  logic [15:0]   poll_cnt_q;

  logic        status_done;
  logic [15:0] poll_cnt_inc;

  // Ready means not busy (bit0 low) and ready flag (bit1) high; other bits are ignored.
  assign status_done  = (status_q == 2'b10);
  assign poll_cnt_inc = poll_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StInit;
      code_q          <= '0;
      wdata_q         <= '0;
      has_rdata_q     <= 1'b0;
      status_q        <= '0;
      rdata_q         <= '0;
      poll_cnt_q      <= '0;
      bus.cmd_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_timeout <= 1'b0;
      bus.init_done   <= 1'b0;
      bus.address     <= '0;
      bus.writedata   <= '0;
      bus.pwrite      <= 1'b1;
      bus.pread       <= 1'b1;
    end else begin
      unique case (state_q)
        // Init reuses the poll/gap pair; init_done low marks the unbounded start-up poll.
        StInit: begin
          bus.pread   <= 1'b0;
          bus.address <= 2'd2;
          state_q     <= StPoll;
        end
        StIdle: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            code_q        <= bus.cmd_code;
            wdata_q       <= bus.cmd_wdata;
            has_rdata_q   <= bus.cmd_has_rdata;
            bus.pwrite    <= 1'b0;
            if (bus.cmd_has_wdata) begin
              bus.address   <= 2'd0;
              bus.writedata <= {24'h0, bus.cmd_wdata};
              state_q       <= StWrData;
            end else begin
              bus.address   <= 2'd1;
              bus.writedata <= 32'(bus.cmd_code);
              state_q       <= StWrCmd;
            end
          end
        end
        StWrData: begin
          bus.pwrite <= 1'b1;
          state_q    <= StWrDataGap;
        end
        StWrDataGap: begin
          bus.pwrite    <= 1'b0;
          bus.address   <= 2'd1;
          bus.writedata <= 32'(code_q);
          state_q       <= StWrCmd;
        end
        StWrCmd: begin
          bus.pwrite <= 1'b1;
          state_q    <= StWrCmdGap;
        end
        StWrCmdGap: begin
          poll_cnt_q    <= '0;
          bus.pread     <= 1'b0;
          bus.address   <= 2'd2;
          bus.writedata <= '0;
          state_q       <= StPoll;
        end
        StPoll: begin
          bus.pread <= 1'b1;
          status_q  <= bus.readdata[1:0];
          state_q   <= StPollGap;
        end
        StPollGap: begin
          if (!bus.init_done) begin
            if (status_done) begin
              bus.init_done <= 1'b1;
              bus.cmd_ready <= 1'b1;
              bus.address   <= 2'd0;
              state_q       <= StIdle;
            end else begin
              bus.pread <= 1'b0;
              state_q   <= StPoll;
            end
          end else if (status_done && has_rdata_q) begin
            bus.pread   <= 1'b0;
            bus.address <= 2'd0;
            state_q     <= StRdData;
          end else if (status_done || (poll_cnt_inc == POLL_TIMEOUT)) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= !status_done;
            bus.address     <= 2'd0;
            state_q         <= StResp;
          end else begin
            poll_cnt_q <= poll_cnt_inc;
            bus.pread  <= 1'b0;
            state_q    <= StPoll;
          end
        end
        StRdData: begin
          bus.pread <= 1'b1;
          rdata_q   <= bus.readdata[7:0];
          state_q   <= StRdGap;
        end
        StRdGap: begin
          bus.rsp_valid   <= 1'b1;
          bus.rsp_rdata   <= rdata_q;
          bus.rsp_timeout <= 1'b0;
          state_q         <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_timeout <= 1'b0;
            bus.cmd_ready   <= 1'b1;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_avalon_host.sv
// Directed bench for nand_avalon_host: a behavioural register slave logs bus accesses and
// each scenario is compared against hand-computed latencies, bus traffic and responses.
module tb_nand_avalon_host;

  logic clk;
  logic resetn;

  nand_avalon_host_if #(.CW(5)) bus ();

  nand_avalon_host #(
    .POLL_TIMEOUT(16'd4),
    .CW          (5)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model state
  int          cyc = 0;
  int          stat_reads = 0;
  int          data_reads = 0;
  int          wr_cnt = 0;
  logic [1:0]  wr_addr[8];
  logic [31:0] wr_data[8];
  int          wr_cyc[8];
  int          busy_limit = 0;
  bit          stuck = 1'b0;
  logic [31:0] done_val = 32'h0000_0002;
  logic [31:0] data_val = 32'h0000_0000;

  // Status reads below busy_limit (or while stuck) report busy.
  assign bus.readdata = (bus.address == 2'd2) ?
                        ((stuck || (stat_reads < busy_limit)) ? 32'h0000_0001 : done_val) :
                        data_val;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.pread && bus.address == 2'd2) stat_reads <= stat_reads + 1;
    if (!bus.pread && bus.address == 2'd0) data_reads <= data_reads + 1;
    if (!bus.pwrite) begin
      wr_addr[wr_cnt % 8] <= bus.address;
      wr_data[wr_cnt % 8] <= bus.writedata;
      wr_cyc[wr_cnt % 8]  <= cyc;
      wr_cnt              <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_init(input string tag, input int exp_reads);
    int base    = stat_reads;
    int k       = 0;
    int spurious = 0;
    while (!bus.init_done && k < 500) begin
      @(negedge clk);
      if (bus.rsp_valid || (bus.cmd_ready && !bus.init_done)) spurious++;
      k++;
    end
    check({tag, "_init_done"}, 32'(bus.init_done), 32'd1);
    check({tag, "_status_reads"}, 32'(stat_reads - base), 32'(exp_reads));
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_no_early_out"}, 32'(spurious), 32'd0);
  endtask

  int wb, sb, db;

  task automatic run_cmd(input string tag, input logic [4:0] code, input logic hw,
                         input logic [7:0] wd, input logic hr, input int exp_lat,
                         input logic [7:0] exp_rdata, input logic exp_to, input int hold);
    int k = 0;
    int lat = -1;
    int unstable = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    wb = wr_cnt;
    sb = stat_reads;
    db = data_reads;
    bus.cmd_code      = code;
    bus.cmd_has_wdata = hw;
    bus.cmd_wdata     = wd;
    bus.cmd_has_rdata = hr;
    bus.cmd_valid     = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = i - 1;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(exp_to));
    // A new request offered during the response must be ignored.
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== exp_rdata || bus.rsp_timeout !== exp_to ||
          bus.cmd_ready) unstable++;
    end
    bus.cmd_valid = 1'b0;
    check({tag, "_rsp_stable"}, 32'(unstable), 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_back_idle"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_code      = '0;
    bus.cmd_wdata     = '0;
    bus.cmd_has_wdata = 1'b0;
    bus.cmd_has_rdata = 1'b0;
    bus.rsp_ready     = 1'b0;
    busy_limit        = 20;
    resetn            = 1'b1;
    #1 resetn = 1'b0;
    #11;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    check("rst_strobes", {30'd0, bus.pread, bus.pwrite}, 32'd3);
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_writedata", bus.writedata, 32'd0);
    check("rst_rsp_data", {23'd0, bus.rsp_timeout, bus.rsp_rdata}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    wait_init("boot", 21);

    // Plain command, no data phases
    run_cmd("c3", 5'd3, 1'b0, 8'h00, 1'b0, 4, 8'h00, 1'b0, 0);
    check("c3_writes", 32'(wr_cnt - wb), 32'd1);
    check("c3_wr_addr", 32'(wr_addr[wb % 8]), 32'd1);
    check("c3_wr_data", wr_data[wb % 8], 32'h3);
    check("c3_status_reads", 32'(stat_reads - sb), 32'd1);

    // Upper status bits set from here on; only [1:0] decide readiness.
    done_val = 32'hFFFF_FFFE;

    run_cmd("c17w", 5'd17, 1'b1, 8'h5A, 1'b0, 6, 8'h00, 1'b0, 0);
    check("c17w_writes", 32'(wr_cnt - wb), 32'd2);
    check("c17w_wr0", {wr_data[wb % 8][29:0], wr_addr[wb % 8]}, {22'd0, 8'h5A, 2'd0});
    check("c17w_wr1", {wr_data[(wb + 1) % 8][29:0], wr_addr[(wb + 1) % 8]},
          {25'd0, 5'h11, 2'd1});
    check("c17w_gap", 32'(wr_cyc[(wb + 1) % 8] - wr_cyc[wb % 8]), 32'd2);
    check("c17w_data_reads", 32'(data_reads - db), 32'd0);

    data_val = 32'hFFFF_FFA7;
    run_cmd("c16r", 5'd16, 1'b0, 8'h00, 1'b1, 6, 8'hA7, 1'b0, 5);
    check("c16r_writes", 32'(wr_cnt - wb), 32'd1);
    check("c16r_wr_data", wr_data[wb % 8], 32'h10);
    check("c16r_data_reads", 32'(data_reads - db), 32'd1);

    data_val = 32'h0000_003C;
    run_cmd("c5wr", 5'd5, 1'b1, 8'h33, 1'b1, 8, 8'h3C, 1'b0, 2);
    check("c5wr_writes", 32'(wr_cnt - wb), 32'd2);
    check("c5wr_data_reads", 32'(data_reads - db), 32'd1);

    // Controller never becomes ready: exactly POLL_TIMEOUT status reads, then abort.
    stuck = 1'b1;
    run_cmd("tmo", 5'd9, 1'b0, 8'h00, 1'b1, 10, 8'h00, 1'b1, 1);
    check("tmo_status_reads", 32'(stat_reads - sb), 32'd4);
    check("tmo_data_reads", 32'(data_reads - db), 32'd0);

    // Reset while polling: outputs clear at once, no response, start-up poll repeats.
    @(negedge clk);
    bus.cmd_code      = 5'd7;
    bus.cmd_has_wdata = 1'b0;
    bus.cmd_has_rdata = 1'b0;
    bus.cmd_valid     = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("arst_init_done", 32'(bus.init_done), 32'd0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_bus", {28'd0, bus.address, bus.pread, bus.pwrite}, 32'd3);
    stuck      = 1'b0;
    busy_limit = stat_reads + 2;
    @(negedge clk);
    resetn = 1'b1;
    wait_init("arst", 3);

    run_cmd("post", 5'd3, 1'b0, 8'h00, 1'b0, 4, 8'h00, 1'b0, 0);
    check("post_wr_data", wr_data[wb % 8], 32'h3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nand_avalon_host.md
NAND_AVALON_HOST -- requirements
Module: nand_avalon_host

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 16'd50000, meaning the max failed status reads per command before the command aborts.
REQ-002 SHALL have parameter CW (command code width), default 5.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 cmd_valid  input  1  host request valid.
REQ-006 cmd_ready  output  1  request accepted when cmd_valid&&cmd_ready at a rising edge.
REQ-007 cmd_code  input  CW  controller command code, written to CMD_REG.
REQ-008 cmd_wdata  input  8  data byte for DATA_REG.
REQ-009 cmd_has_wdata  input  1  1 = write DATA_REG before CMD_REG.
REQ-010 cmd_has_rdata  input  1  1 = read DATA_REG after completion.
REQ-011 rsp_valid  output  1  response valid, held until accepted.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready at a rising edge.
REQ-013 rsp_rdata  output  8  byte read from DATA_REG, 0 if none or on timeout.
REQ-014 rsp_timeout  output  1  1 = status poll exceeded POLL_TIMEOUT.
REQ-015 init_done  output  1  1 once the controller has first reported ready after reset.
REQ-016 address  output  2  slave register select: 0 DATA_REG, 1 CMD_REG, 2 STATUS_REG.
REQ-017 writedata  output  32  slave write data, upper 24 bits 0.
REQ-018 pwrite  output  1  active-low write strobe.
REQ-019 pread  output  1  active-low read strobe.
REQ-020 readdata  input  32  slave read data; only [7:0] used.

Function
REQ-021 SHALL register all outputs; idle bus values: pread=1, pwrite=1, address=0, writedata=0.
REQ-022 Write access SHALL be one strobe cycle (pwrite=0, pread=1, address/writedata valid) followed by one gap cycle (pwrite=1, address/writedata held).
REQ-023 Read access SHALL be one cycle with pread=0, pwrite=1; readdata[7:0] captured at the rising edge ending that cycle, followed by one idle gap cycle.
REQ-024 Status "done" SHALL mean captured status bit0==0 (not busy) and bit1==1 (ready); otherwise "pending".
REQ-025 States: INIT, IDLE, WR_DATA, WR_DATA_GAP, WR_CMD, WR_CMD_GAP, POLL, POLL_GAP, RD_DATA, RD_GAP, RESP.
REQ-026 INIT SHALL repeat status reads (POLL/POLL_GAP timing) until "done", with no timeout, then set init_done=1 permanently and enter IDLE.
REQ-027 cmd_ready SHALL be 1 only in IDLE; on accept, request fields SHALL be latched and state goes to WR_DATA if cmd_has_wdata else WR_CMD.
REQ-028 WR_DATA SHALL write {24'h0,cmd_wdata} to address 0; WR_CMD SHALL write {'0,cmd_code} to address 1; each followed by its gap state.
REQ-029 WR_CMD_GAP SHALL clear the poll counter and enter POLL; POLL reads address 2.
REQ-030 POLL_GAP: if "done" -> RD_DATA if cmd_has_rdata else RESP; if pending and counter+1==POLL_TIMEOUT -> RESP with rsp_timeout=1; else counter+1, back to POLL.
REQ-031 RD_DATA reads address 0; the captured byte SHALL become rsp_rdata; RD_GAP -> RESP.
REQ-032 RESP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_timeout until rsp_ready, then return to IDLE the next cycle; rsp_rdata=0 when timed out or no read.
REQ-033 Latency, accept at edge E, status done on first poll: no-data command -> rsp_valid at E+4; with read -> E+6; with write and read -> E+8.
REQ-034 Poll counter SHALL be 16 bits, saturate-free because it is bounded by POLL_TIMEOUT; POLL_TIMEOUT=1 SHALL allow exactly one status read.
REQ-035 cmd_valid while not in IDLE SHALL be ignored (not accepted, not queued); rsp_ready outside RESP SHALL be ignored.
REQ-036 A readdata value other than [1:0] bits SHALL not affect the done decision.

Reset
REQ-037 While resetn=0: state INIT, init_done=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, bus outputs at idle values, counters 0.
REQ-038 Reset asserted mid-access SHALL immediately return outputs to REQ-037 values; after release, INIT restarts; the in-flight command is discarded with no response.

Verification
REQ-039 Status returns 0x01 for 20 reads then 0x02 -> init_done rises after the 21st status read; cmd_ready=1 the cycle after.
REQ-040 cmd_code=3, no data, status 0x02 -> one write to address 1 of 0x3, one read of address 2, rsp_valid at E+4, rsp_rdata=0, rsp_timeout=0.
REQ-041 cmd_code=17, cmd_has_wdata=1, cmd_wdata=0x5A -> write addr0 0x5A, then addr1 0x11, strobes separated by one gap cycle, response without read.
REQ-042 cmd_code=16, cmd_has_rdata=1, slave DATA_REG=0xA7 -> rsp_rdata=0xA7 at E+6; rsp_ready held 0 for 5 cycles -> rsp_valid and data stable throughout.
REQ-043 POLL_TIMEOUT=4, status stuck 0x01 -> exactly 4 status reads, rsp_timeout=1, rsp_rdata=0, no DATA_REG read.
REQ-044 resetn pulsed low during POLL -> all outputs reset asynchronously, no rsp_valid; INIT repeats before the next accept.
